retire_queue: RTL

In-order retire queue that feeds the commit stage. It allocates one slot per issued instruction and captures functional-unit writebacks by transaction ID. It presents the oldest `NR_COMMIT_PORTS` completed entries as `scoreboard_entry_t` and frees slots on `commit_ack`. It is the producer side of the commit interface, sitting between issue/writeback and `commit_stage`.

---
 rtl/ariane_pkg.sv | 30 +++
 rtl/retire_queue_ack_mask.sv | 31 +++
 rtl/retire_queue.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/ariane_pkg.sv
// Shared core types used by the retire queue and its neighbours.
// riscv: architectural widths. ariane_pkg: transaction ID width, exception and
// scoreboard entry records exchanged between issue, writeback and commit.
package riscv;
  localparam int XLEN = 64;
endpackage

package ariane_pkg;
  localparam int NR_SB_ENTRIES = 8;
  localparam int TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);

  typedef struct packed {
    logic [riscv::XLEN-1:0] cause;
    logic [riscv::XLEN-1:0] tval;
    logic                   valid;
  } exception_t;

  typedef struct packed {
    logic [riscv::XLEN-1:0]   pc;
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [3:0]               fu;
    logic [7:0]               op;
    logic [4:0]               rs1;
    logic [4:0]               rs2;
    logic [4:0]               rd;
    logic [riscv::XLEN-1:0]   result;
    logic                     valid;
    exception_t               ex;
  } scoreboard_entry_t;
endpackage

// File: rtl/retire_queue_ack_mask.sv
// Turns raw commit acks into the effective-ack vector: an ack counts only when
// its port is valid and every lower port is also effectively acked.
// Ports: i_ack / i_valid per commit port in; o_eff per port and o_pop_cnt out.
// Purely combinational.
module retire_queue_ack_mask #(
  parameter int NR_COMMIT_PORTS = 2,
  parameter int CNT_W           = 4
) (
  input  logic [NR_COMMIT_PORTS-1:0] i_ack,
  input  logic [NR_COMMIT_PORTS-1:0] i_valid,
  output logic [NR_COMMIT_PORTS-1:0] o_eff,
  output logic [CNT_W-1:0]           o_pop_cnt
);

  logic w_chain;

  always_comb begin
    w_chain   = 1'b1;
    o_eff     = '0;
    o_pop_cnt = '0;
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      // A gap in the ack pattern breaks the chain for every higher port.
      w_chain  = w_chain & i_ack[i] & i_valid[i];
      o_eff[i] = w_chain;
      if (w_chain) begin
        o_pop_cnt = o_pop_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/retire_queue.sv
// In-order retire queue: allocates a slot per issued instruction, captures
// writebacks by transaction ID and presents the oldest completed entries to commit.
// Ports: clk_i/rst_ni/flush_i; issue_valid_i/issue_instr_i -> issue_ready_o,
// issue_trans_id_o; wb_*_i per writeback port; commit_instr_o, commit_ack_i.
// Optional macro RETIRE_QUEUE_WB_BYPASS_EN forwards same-cycle writebacks into
// the commit view; without it the view is built from registered state only.
module retire_queue
  import ariane_pkg::*;
#(
  parameter int NR_ENTRIES      = NR_SB_ENTRIES,
  parameter int NR_COMMIT_PORTS = 2,
  parameter int NR_WB_PORTS     = 4
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic                                        flush_i,
  input  logic                                        issue_valid_i,
  input  scoreboard_entry_t                           issue_instr_i,
  output logic                                        issue_ready_o,
  output logic [TRANS_ID_BITS-1:0]                    issue_trans_id_o,
  input  logic [NR_WB_PORTS-1:0]                      wb_valid_i,
  input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]   wb_trans_id_i,
  input  logic [NR_WB_PORTS-1:0][riscv::XLEN-1:0]     wb_result_i,
  input  exception_t [NR_WB_PORTS-1:0]                wb_ex_i,
  output scoreboard_entry_t [NR_COMMIT_PORTS-1:0]     commit_instr_o,
  input  logic [NR_COMMIT_PORTS-1:0]                  commit_ack_i
);

  localparam int PTR_W    = $clog2(NR_ENTRIES);
  localparam int CNT_W    = PTR_W + 1;
  localparam int WB_SEL_W = (NR_WB_PORTS > 1) ? $clog2(NR_WB_PORTS) : 1;

  scoreboard_entry_t         r_mem [NR_ENTRIES];
  logic [NR_ENTRIES-1:0]     r_busy;
  logic [NR_ENTRIES-1:0]     r_done;
  logic [PTR_W-1:0]          r_head;
  logic [PTR_W-1:0]          r_tail;
  logic [CNT_W-1:0]          r_cnt;

  logic                      w_issue;
  logic [NR_ENTRIES-1:0]     w_wb_hit;
  logic [WB_SEL_W-1:0]       w_wb_sel [NR_ENTRIES];
  logic [PTR_W-1:0]          w_cidx   [NR_COMMIT_PORTS];
  logic [NR_COMMIT_PORTS-1:0] w_view_done;
  logic [NR_COMMIT_PORTS-1:0] w_commit_vld;
  logic [NR_COMMIT_PORTS-1:0] w_ack_eff;
  logic [CNT_W-1:0]          w_pop_cnt;

  assign issue_ready_o    = (r_cnt < CNT_W'(NR_ENTRIES));
  assign issue_trans_id_o = TRANS_ID_BITS'(r_tail);
  assign w_issue          = issue_valid_i && issue_ready_o;

  // Per-slot writeback select; scanning from the top down lets the lowest
  // matching port overwrite the choice, so it wins on collisions.
  always_comb begin
    for (int s = 0; s < NR_ENTRIES; s++) begin
      w_wb_hit[s] = 1'b0;
      w_wb_sel[s] = '0;
      for (int p = NR_WB_PORTS - 1; p >= 0; p--) begin
        if (wb_valid_i[p] && (wb_trans_id_i[p] == TRANS_ID_BITS'(s))) begin
          w_wb_hit[s] = 1'b1;
          w_wb_sel[s] = WB_SEL_W'(p);
        end
      end
    end
  end

  // Commit view: oldest entries starting at the head, head first.
  always_comb begin
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      w_cidx[i]         = r_head + PTR_W'(i);
      commit_instr_o[i] = r_mem[w_cidx[i]];
      w_view_done[i]    = r_done[w_cidx[i]];
`ifdef RETIRE_QUEUE_WB_BYPASS_EN
      if (w_wb_hit[w_cidx[i]] && r_busy[w_cidx[i]]) begin
        commit_instr_o[i].result = wb_result_i[w_wb_sel[w_cidx[i]]];
        if (wb_ex_i[w_wb_sel[w_cidx[i]]].valid) begin
          commit_instr_o[i].ex = wb_ex_i[w_wb_sel[w_cidx[i]]];
        end
        w_view_done[i] = 1'b1;
      end
`endif
      w_commit_vld[i]         = (CNT_W'(i) < r_cnt) && r_busy[w_cidx[i]] && w_view_done[i];
      commit_instr_o[i].valid = w_commit_vld[i];
    end
  end

  retire_queue_ack_mask #(
    .NR_COMMIT_PORTS (NR_COMMIT_PORTS),
    .CNT_W           (CNT_W)
  ) u_ack_mask (
    .i_ack     (commit_ack_i),
    .i_valid   (w_commit_vld),
    .o_eff     (w_ack_eff),
    .o_pop_cnt (w_pop_cnt)
  );

  // Entry payload carries no reset; busy/done qualify it.
  always_ff @(posedge clk_i) begin
    if (!flush_i) begin
      for (int s = 0; s < NR_ENTRIES; s++) begin
        if (w_wb_hit[s] && r_busy[s]) begin
          r_mem[s].result <= wb_result_i[w_wb_sel[s]];
          if (wb_ex_i[w_wb_sel[s]].valid) begin
            r_mem[s].ex <= wb_ex_i[w_wb_sel[s]];
          end
        end
      end
      // The tail slot is never busy when issue is accepted, so it cannot
      // collide with a writeback above.
      if (w_issue) begin
        r_mem[r_tail]          <= issue_instr_i;
        r_mem[r_tail].trans_id <= TRANS_ID_BITS'(r_tail);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_busy <= '0;
      r_done <= '0;
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else if (flush_i) begin
      r_busy <= '0;
      r_done <= '0;
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else begin
      for (int s = 0; s < NR_ENTRIES; s++) begin
        if (w_wb_hit[s] && r_busy[s]) begin
          r_done[s] <= 1'b1;
        end
      end
      // Retirement is ordered after writeback so a slot freed this cycle
      // stays clear even if a late writeback targets it.
      for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
        if (w_ack_eff[i]) begin
          r_busy[w_cidx[i]] <= 1'b0;
          r_done[w_cidx[i]] <= 1'b0;
        end
      end
      if (w_issue) begin
        r_busy[r_tail] <= 1'b1;
        r_done[r_tail] <= issue_instr_i.ex.valid;
        r_tail         <= r_tail + PTR_W'(1);
      end
      r_head <= r_head + PTR_W'(w_pop_cnt);
      r_cnt  <= r_cnt + CNT_W'(w_issue) - w_pop_cnt;
    end
  end

endmodule
